// File: rtl/cdb_arbiter_if.sv
// Common-data-bus arbitration bundle: FU result requests in, grants and the
// registered N-slot CDB broadcast out.
interface cdb_arbiter_if #(
    parameter int NUM_REQ = 8,
    parameter int N       = 2,
    parameter int TAG_W   = 6,
    parameter int XLEN    = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0][TAG_W-1:0] req_tag;
    logic [NUM_REQ-1:0][XLEN-1:0]  req_value;
    logic [NUM_REQ-1:0]            grant;
    logic [N-1:0]                  cdb_valid;
    logic [N-1:0][TAG_W-1:0]       cdb_tag;
    logic [N-1:0][XLEN-1:0]        cdb_value;

    modport slave (
        input  req_valid, req_tag, req_value,
        output grant, cdb_valid, cdb_tag, cdb_value
    );

    modport master (
        output req_valid, req_tag, req_value,
        input  grant, cdb_valid, cdb_tag, cdb_value
    );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants up to N FU results per cycle with rotating priority and
// starvation promotion, then registers the winners onto the broadcast slots.
module cdb_arbiter #(
    parameter int NUM_REQ  = 8,
    parameter int N        = 2,
    parameter int TAG_W    = 6,
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          squash_i,
    cdb_arbiter_if.slave  bus
);
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);

    logic [PTR_W-1:0]               rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0][WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [N-1:0]                   cdb_valid_q, cdb_valid_d;
    logic [N-1:0][TAG_W-1:0]        cdb_tag_q, cdb_tag_d;
    logic [N-1:0][XLEN-1:0]         cdb_value_q, cdb_value_d;

    logic [NUM_REQ-1:0]             urgent_s;
    logic [NUM_REQ-1:0]             grant_s;
    logic [N-1:0]                   slot_vld_s;
    logic [N-1:0][PTR_W-1:0]        slot_idx_s;
    logic [PTR_W-1:0]               last_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_IDX) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Urgency flags: requesting and already starved for MAX_WAIT cycles.
    always_comb begin
        urgent_s = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            urgent_s[i] = bus.req_valid[i] && (wait_cnt_q[i] == WAIT_SAT);
        end
    end

    // Two-pass selection: urgent first, then normal; slots fill in selection order.
    always_comb begin : arb_sel
        logic [PTR_W-1:0] idx;
        logic             cand;
        logic             placed;
        grant_s    = {NUM_REQ{1'b0}};
        slot_vld_s = {N{1'b0}};
        slot_idx_s = '0;
        last_s     = rr_ptr_q;
        idx        = rr_ptr_q;
        cand       = 1'b0;
        placed     = 1'b0;
        if (!squash_i) begin
            for (int p = 0; p < 2; p++) begin
                idx = rr_ptr_q;
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (p == 0) begin
                        cand = urgent_s[idx];
                    end else begin
                        cand = bus.req_valid[idx] && !grant_s[idx];
                    end
                    placed = 1'b0;
                    for (int s = 0; s < N; s++) begin
                        if (cand && !placed && !slot_vld_s[s]) begin
                            slot_vld_s[s] = 1'b1;
                            slot_idx_s[s] = idx;
                            placed        = 1'b1;
                        end else begin
                            placed = placed;
                        end
                    end
                    if (placed) begin
                        grant_s[idx] = 1'b1;
                        last_s       = idx;
                    end else begin
                        last_s = last_s;
                    end
                    idx = ptr_inc(idx);
                end
            end
        end else begin
            grant_s = {NUM_REQ{1'b0}};
        end
    end

    // Next-state for pointer, starvation counters and broadcast slots.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        wait_cnt_d  = wait_cnt_q;
        cdb_valid_d = slot_vld_s;
        cdb_tag_d   = '0;
        cdb_value_d = '0;
        if (|grant_s) begin
            rr_ptr_d = ptr_inc(last_s);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (squash_i || grant_s[i] || !bus.req_valid[i]) begin
                wait_cnt_d[i] = {WAIT_W{1'b0}};
            end else if (wait_cnt_q[i] == WAIT_SAT) begin
                wait_cnt_d[i] = WAIT_SAT;
            end else begin
                wait_cnt_d[i] = wait_cnt_q[i] + WAIT_W'(1);
            end
        end
        // Unused slots broadcast zero tag/value so stale data never leaks.
        for (int s = 0; s < N; s++) begin
            if (slot_vld_s[s]) begin
                cdb_tag_d[s]   = bus.req_tag[slot_idx_s[s]];
                cdb_value_d[s] = bus.req_value[slot_idx_s[s]];
            end else begin
                cdb_tag_d[s]   = {TAG_W{1'b0}};
                cdb_value_d[s] = {XLEN{1'b0}};
            end
        end
    end

    // State and broadcast registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q    <= {PTR_W{1'b0}};
            wait_cnt_q  <= '0;
            cdb_valid_q <= {N{1'b0}};
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            wait_cnt_q  <= wait_cnt_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_value_q <= cdb_value_d;
        end
    end

    assign bus.grant     = grant_s;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_value = cdb_value_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter followed by a randomized invariant sweep.
module tb_cdb_arbiter;
    logic clk;
    logic rst_n;
    logic squash;
    int   n_cmp;
    int   n_err;

    cdb_arbiter_if #(.NUM_REQ(8), .N(2), .TAG_W(6), .XLEN(32)) bus ();

    cdb_arbiter #(.NUM_REQ(8), .N(2), .TAG_W(6), .XLEN(32), .MAX_WAIT(3)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .squash_i (squash),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] tg(input int i);
        return 6'(8 + i);
    endfunction

    function automatic logic [31:0] vl(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  rr_grant [5] = '{8'h03, 8'h0C, 8'h30, 8'hC0, 8'h03};
    int          rr_first [5] = '{0, 2, 4, 6, 0};
    int          rr_ptr_x [5] = '{2, 4, 6, 0, 2};
    logic [7:0]  gnt;
    logic [7:0]  vsave;
    logic [31:0] vals [8];
    logic [31:0] r;
    int          hits;

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        squash = 1'b0;
        n_cmp = 0;
        n_err = 0;
        bus.req_valid = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bus.req_tag[i]   = tg(i);
            bus.req_value[i] = vl(i);
        end
        #2;
        chk("rst_cdb_valid", 64'(bus.cdb_valid), 64'h0);
        chk("rst_cdb_tag",   64'(bus.cdb_tag),   64'h0);
        chk("rst_cdb_value", 64'(bus.cdb_value), 64'h0);
        chk("rst_grant",     64'(bus.grant),     64'h0);
        chk("rst_rr_ptr",    64'(dut.rr_ptr_q),  64'h0);
        edge_step();
        rst_n = 1'b1;

        // Reset mid-stream
        bus.req_valid = 8'hFF;
        #1 chk("pre_rst_grant", 64'(bus.grant), 64'h03);
        edge_step();
        chk("pre_rst_cdb_valid", 64'(bus.cdb_valid), 64'h3);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_cdb_valid", 64'(bus.cdb_valid), 64'h0);
        bus.req_valid = 8'h00;
        #1 chk("rst_idle_grant", 64'(bus.grant), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = 8'h03;
        #1 chk("post_rst_grant", 64'(bus.grant), 64'h03);
        edge_step();
        chk("post_rst_cdb_tag", 64'(bus.cdb_tag), 64'({tg(1), tg(0)}));
        chk("post_rst_cdb_valid", 64'(bus.cdb_valid), 64'h3);
        chk("post_rst_rr", 64'(dut.rr_ptr_q), 64'd2);

        // Single requester 7 to bring the pointer back to 0
        bus.req_valid = 8'h80;
        #1 chk("solo7_grant", 64'(bus.grant), 64'h80);
        edge_step();
        chk("solo7_cdb_valid", 64'(bus.cdb_valid), 64'h1);
        chk("solo7_cdb_tag0", 64'(bus.cdb_tag[0]), 64'(tg(7)));
        chk("solo7_rr", 64'(dut.rr_ptr_q), 64'd0);

        // Round-robin rotation, all requesting
        for (int c = 0; c < 5; c++) begin
            bus.req_valid = 8'hFF;
            #1 chk($sformatf("rr%0d_grant", c), 64'(bus.grant), 64'(rr_grant[c]));
            edge_step();
            chk($sformatf("rr%0d_ptr", c), 64'(dut.rr_ptr_q), 64'(rr_ptr_x[c]));
            chk($sformatf("rr%0d_tag", c), 64'(bus.cdb_tag),
                64'({tg(rr_first[c] + 1), tg(rr_first[c])}));
        end

        // Idle cycle
        bus.req_valid = 8'h00;
        #1 chk("idle_grant", 64'(bus.grant), 64'h0);
        edge_step();
        chk("idle_cdb_valid", 64'(bus.cdb_valid), 64'h0);
        chk("idle_rr", 64'(dut.rr_ptr_q), 64'd2);

        // Underfill
        bus.req_valid = 8'h10;
        #1 chk("under_grant", 64'(bus.grant), 64'h10);
        edge_step();
        chk("under_cdb_valid", 64'(bus.cdb_valid), 64'h1);
        chk("under_tag0", 64'(bus.cdb_tag[0]), 64'(tg(4)));
        chk("under_value0", 64'(bus.cdb_value[0]), 64'(vl(4)));
        chk("under_rr", 64'(dut.rr_ptr_q), 64'd5);

        bus.req_valid = 8'h80;
        #1 chk("wrap_grant", 64'(bus.grant), 64'h80);
        edge_step();
        chk("wrap_rr", 64'(dut.rr_ptr_q), 64'd0);

        // Starvation promotion of requester 7
        bus.req_valid = 8'h83;
        #1 chk("starve1_grant", 64'(bus.grant), 64'h03);
        edge_step();
        chk("starve1_wait7", 64'(dut.wait_cnt_q[7]), 64'd1);
        bus.req_valid = 8'h8C;
        #1 chk("starve2_grant", 64'(bus.grant), 64'h0C);
        edge_step();
        chk("starve2_wait7", 64'(dut.wait_cnt_q[7]), 64'd2);
        bus.req_valid = 8'hB0;
        #1 chk("starve3_grant", 64'(bus.grant), 64'h30);
        edge_step();
        chk("starve3_wait7", 64'(dut.wait_cnt_q[7]), 64'd3);
        chk("starve3_rr", 64'(dut.rr_ptr_q), 64'd6);
        bus.req_valid = 8'hC1;
        #1 chk("urgent_grant", 64'(bus.grant), 64'hC0);
        edge_step();
        chk("urgent_slots", 64'(bus.cdb_tag), 64'({tg(6), tg(7)}));
        chk("urgent_wait7", 64'(dut.wait_cnt_q[7]), 64'd0);
        chk("urgent_wait0", 64'(dut.wait_cnt_q[0]), 64'd1);
        chk("urgent_rr", 64'(dut.rr_ptr_q), 64'd7);

        // Squash
        bus.req_valid = 8'hFF;
        #1 chk("presq_grant", 64'(bus.grant), 64'h81);
        edge_step();
        chk("presq_rr", 64'(dut.rr_ptr_q), 64'd1);
        squash = 1'b1;
        #1 chk("sq_grant", 64'(bus.grant), 64'h0);
        chk("sq_held_valid", 64'(bus.cdb_valid), 64'h3);
        chk("sq_held_tag", 64'(bus.cdb_tag), 64'({tg(0), tg(7)}));
        edge_step();
        squash = 1'b0;
        chk("postsq_cdb_valid", 64'(bus.cdb_valid), 64'h0);
        chk("postsq_wait", 64'(dut.wait_cnt_q), 64'h0);
        chk("postsq_rr", 64'(dut.rr_ptr_q), 64'd1);
        #1 chk("resume_grant", 64'(bus.grant), 64'h06);
        edge_step();
        chk("resume_tag", 64'(bus.cdb_tag), 64'({tg(2), tg(1)}));

        // Random invariant sweep
        for (int c = 0; c < 300; c++) begin
            r = $urandom;
            bus.req_valid = r[7:0];
            squash = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < 8; i++) begin
                r = $urandom;
                bus.req_value[i] = {r[23:0], 8'(i)};
                vals[i] = {r[23:0], 8'(i)};
            end
            #1;
            gnt = bus.grant;
            vsave = bus.req_valid;
            chk("inv_popcount", 64'($countones(gnt) <= 2), 64'd1);
            chk("inv_subset", 64'(gnt & ~vsave), 64'h0);
            edge_step();
            squash = 1'b0;
            chk("inv_slot_count", 64'($countones(bus.cdb_valid)), 64'($countones(gnt)));
            if (bus.cdb_valid == 2'b11) begin
                chk("inv_dup_tag", 64'(bus.cdb_tag[0] == bus.cdb_tag[1]), 64'd0);
            end
            for (int i = 0; i < 8; i++) begin
                if (gnt[i]) begin
                    hits = 0;
                    for (int s = 0; s < 2; s++) begin
                        if (bus.cdb_valid[s] && bus.cdb_value[s] == vals[i]) begin
                            hits++;
                        end
                    end
                    chk($sformatf("inv_value_once_%0d", i), 64'(hits), 64'd1);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
